if_fetch_stage: RTL and testbench

- Instruction-fetch stage that drives the combinational instruction ROM port (`ce`, `addr` out, `inst` back).
- Owns the program counter.
- Captures each fetched word together with its PC into a small FIFO, and presents the FIFO head to the decode stage over a valid/ready handshake.
- Accepts a redirect (branch/jump/flush) from execute, which discards all buffered words and restarts fetch at the target.

---
 rtl/if_fetch_stage_pkg.sv | 29 ++
 rtl/if_fetch_stage_fetch_fifo.sv | 63 ++++++
 rtl/if_fetch_stage.sv | 88 ++++++++
 tb/tb_if_fetch_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants; also carries the legacy instruction-bus defines.
`ifndef IF_FETCH_STAGE_DEFINES
`define IF_FETCH_STAGE_DEFINES
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h0000_0000
`define ReadEnable  1'b1
`define ReadDisable 1'b0
`define InstStep    32'd4
`endif

package if_fetch_stage_pkg;

  localparam logic [`InstAddrBus] ZERO_WORD    = `ZeroWord;
  localparam logic [`InstAddrBus] INST_STEP    = `InstStep;
  localparam logic                READ_ENABLE  = `ReadEnable;
  localparam logic                READ_DISABLE = `ReadDisable;

  typedef enum logic {
    FS_IDLE,
    FS_RUN
  } fetch_state_e;

  typedef struct packed {
    logic [`InstAddrBus] pc;
    logic [`InstBus]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} pairs; push+pop allowed when full, flush wins.
module fetch_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         empty,
  output logic         full
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives the combinational ROM port and buffers fetched words for decode.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         run;
  logic [31:0]  pc_q;
  logic         pop;
  logic         push_ok;
  logic         fifo_empty;
  logic         fifo_full;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  // Idle only for the single cycle after reset, so the first ROM access lags release by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE: state_d = FS_RUN;
      FS_RUN:  state_d = FS_RUN;
      default: state_d = FS_IDLE;
    endcase
  end

  always_comb begin
    run = 1'b0;
    unique case (state_q)
      FS_RUN:  run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  assign pop        = id_valid_o & id_ready_i;
  assign push_ok    = ~fifo_full | pop;
  assign rom_ce_o   = (run & push_ok & ~redirect_i) ? READ_ENABLE : READ_DISABLE;
  assign rom_addr_o = rom_ce_o ? pc_q : ZERO_WORD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pc_q <= RESET_PC;
    else if (redirect_i) pc_q <= redirect_addr_i & ~32'h0000_0003;
    else if (rom_ce_o)   pc_q <= pc_q + INST_STEP;
  end

  assign wr_entry = '{pc: pc_q, inst: rom_inst_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (rom_ce_o),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign id_valid_o = ~fifo_empty;
  assign id_pc_o    = head.pc;
  assign id_inst_o  = head.inst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a combinational ROM model answering addr ^ constant.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_ready_i      (id_ready_i)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // A disabled ROM returns zero, which must never show up at decode.
  assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] addr);
    check({tag, "_ce"}, {31'b0, rom_ce_o}, 32'd1);
    check({tag, "_addr"}, rom_addr_o, addr);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ce"}, {31'b0, rom_ce_o}, 32'd0);
    check({tag, "_addr"}, rom_addr_o, 32'h0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, id_valid_o}, 32'd1);
    check({tag, "_pc"}, id_pc_o, pc);
    check({tag, "_inst"}, id_inst_o, rom_word(pc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle(tag);
    check({tag, "_valid"}, {31'b0, id_valid_o}, 32'd0);
    check({tag, "_pc"}, id_pc_o, 32'h0);
    check({tag, "_inst"}, id_inst_o, 32'h0);
  endtask

  initial begin
    // Reset state
    @(negedge clk); #1;
    check_reset_outputs("rst");

    // Release with ready=1: first fetch one cycle later, then one word per cycle
    @(negedge clk); rst = 1'b0; #1;
    check_idle("t1_run0");
    @(negedge clk); #1;
    check_fetch("t1_f0", 32'h0);
    check("t1_v0", {31'b0, id_valid_o}, 32'd0);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk); #1;
      check_fetch("t1_f", 32'(4 * k));
      check_head("t1_h", 32'(4 * (k - 1)));
    end

    // Asynchronous reset between edges while streaming
    @(posedge clk); #2; rst = 1'b1; #1;
    check_reset_outputs("arst");

    // Stall with ready=0: only two fetches, head stable
    @(negedge clk); rst = 1'b0; id_ready_i = 1'b0; #1;
    check_idle("t2_run0");
    @(negedge clk); #1;
    check_fetch("t2_f0", 32'h0);
    check("t2_v0", {31'b0, id_valid_o}, 32'd0);
    @(negedge clk); #1;
    check_fetch("t2_f4", 32'h4);
    check_head("t2_h0a", 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check_idle("t2_full");
      check_head("t2_hold", 32'h0);
    end

    // Ready again: full FIFO pushes and pops in the same cycle, no bubble
    @(negedge clk); id_ready_i = 1'b1; #1;
    check_fetch("t3_f8", 32'h8);
    check_head("t3_h0", 32'h0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      check_fetch("t3_f", 32'(8 + 4 * k));
      check_head("t3_h", 32'(4 * k));
    end

    // Redirect with two entries buffered
    @(negedge clk); id_ready_i = 1'b0; #1;
    check_idle("t4_full");
    check_head("t4_h16", 32'h10);
    @(negedge clk); redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103; #1;
    check_idle("t4_redir");
    @(negedge clk); redirect_i = 1'b0; #1;
    check("t4_flushed", {31'b0, id_valid_o}, 32'd0);
    check_fetch("t4_f100", 32'h100);
    @(negedge clk); id_ready_i = 1'b1; #1;
    check_head("t4_h100", 32'h100);
    check_fetch("t4_f104", 32'h104);
    @(negedge clk); #1;
    check_head("t4_h104", 32'h104);

    // Redirect coinciding with a pop: head still offered, then discarded
    @(negedge clk); redirect_i = 1'b1; redirect_addr_i = 32'h0000_0200; #1;
    check_idle("t4b_redir");
    check_head("t4b_h108", 32'h108);
    @(negedge clk); redirect_i = 1'b0; #1;
    check("t4b_flushed", {31'b0, id_valid_o}, 32'd0);
    check_fetch("t4b_f200", 32'h200);

    // Redirect in the first cycle after reset
    @(negedge clk); rst = 1'b1; #1;
    check_reset_outputs("t6_rst");
    @(negedge clk); rst = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'h0000_0080; #1;
    check_idle("t6_run0");
    @(negedge clk); redirect_i = 1'b0; #1;
    check_fetch("t6_f80", 32'h80);
    check("t6_v0", {31'b0, id_valid_o}, 32'd0);
    @(negedge clk); #1;
    check_fetch("t6_f84", 32'h84);
    check_head("t6_h80", 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
